// File: rtl/aes_enc_feeder.sv
// aes_enc_feeder: packs big-endian 32-bit plaintext words into 128-bit blocks,
// buffers up to FIFO_DEPTH blocks and issues them to aes_core one at a time,
// counting completed blocks.
// Define AES_FEEDER_CBC_EN to build the CBC chain register; otherwise ECB.
module aes_enc_feeder #(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [31:0]  in_data,
  output logic         in_ready,
  input  logic [127:0] iv,
  input  logic         iv_load,
  input  logic         ready_key,
  input  logic         iready_enc,
  input  logic         oready_enc,
  input  logic [127:0] result_enc,
  output logic [127:0] block_enc,
  output logic         reset_enc,
  output logic         busy,
  output logic [15:0]  blk_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, START, GUARD, WAIT} state_t;

  state_t        state, state_nxt;
  logic [1:0]    word_cnt;
  logic [95:0]   staging;
  logic [127:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full;
  logic          word_fire, push, pop, iv_take;
  logic [127:0]  head, issue_blk;
  logic [15:0]   done_cnt;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign in_ready   = (word_cnt != 2'd3) || !fifo_full;
  assign word_fire  = in_valid && in_ready;
  assign push       = word_fire && (word_cnt == 2'd3);
  assign head       = fifo_mem[rd_ptr[AW-1:0]];
  assign pop        = (state == IDLE) && !fifo_empty && ready_key &&
                      iready_enc && !iv_take;
  assign blk_count  = done_cnt;

`ifdef AES_FEEDER_CBC_EN
  logic [127:0] chain;

  assign iv_take   = iv_load && (state == IDLE);
  assign issue_blk = head ^ chain;

  // Chain register: IV load in IDLE, otherwise last ciphertext on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            chain <= '0;
    else if (iv_take)                     chain <= iv;
    else if (state == WAIT && oready_enc) chain <= result_enc;
  end
`else
  logic unused_cbc;

  assign iv_take    = 1'b0;
  assign issue_blk  = head;
  assign unused_cbc = ^{iv, iv_load, result_enc};
`endif

  // Word packing: first three words staged, fourth completes the block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_cnt <= '0;
      staging  <= '0;
    end else if (word_fire) begin
      word_cnt <= word_cnt + 2'd1;
      case (word_cnt)
        2'd0:    staging[95:64] <= in_data;
        2'd1:    staging[63:32] <= in_data;
        2'd2:    staging[31:0]  <= in_data;
        default: ;
      endcase
    end
  end

  // Block FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {staging, in_data};
  end

  // FIFO pointers; push and pop may occur together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Issued block is captured only on the IDLE->START transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    block_enc <= '0;
    else if (pop) block_enc <= issue_blk;
  end

  // Completed-block counter, wraps modulo 2^16.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            done_cnt <= '0;
    else if (state == WAIT && oready_enc) done_cnt <= done_cnt + 16'd1;
  end

  // Issue FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Issue FSM next-state; GUARD lets the core drop a stale oready_enc.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = START;
      START:   state_nxt = GUARD;
      GUARD:   state_nxt = WAIT;
      WAIT:    if (oready_enc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue FSM outputs.
  always_comb begin
    reset_enc = (state == START);
    busy      = (state != IDLE) || !fifo_empty || (word_cnt != 2'd0);
  end

endmodule

// File: tb/tb_aes_enc_feeder.sv
// Self-checking bench for aes_enc_feeder with a behavioural aes_core model
// and a block scoreboard. CBC steps are built when AES_FEEDER_CBC_EN is defined.
module tb_aes_enc_feeder;

  localparam logic [127:0] FIPS_PT = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] FIPS_CT = 128'h3925841d_02dc09fb_dc118597_196a0b32;
  localparam logic [127:0] CBC_IV  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [127:0] CBC_PT1 = 128'h6bc1bee2_2e409f96_e93d7e11_7393172a;
  localparam logic [127:0] CBC_PT2 = 128'hae2d8a57_1e03ac9c_9eb76fac_45af8e51;
  localparam logic [127:0] CBC_B1  = 128'h6bc0bce1_2a459991_e134741a_7f9e1925;
  localparam logic [127:0] CBC_C1  = 128'h7649abac_8119b246_cee98e9b_12e9197d;
`ifdef AES_FEEDER_CBC_EN
  localparam bit CBC = 1'b1;
`else
  localparam bit CBC = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_ready;
  logic [127:0] iv = '0;
  logic         iv_load = 1'b0;
  logic         ready_key = 1'b1;
  logic         iready_enc = 1'b1;
  logic         oready_enc = 1'b0;
  logic [127:0] result_enc = '0;
  logic [127:0] block_enc;
  logic         reset_enc;
  logic         busy;
  logic [15:0]  blk_count;

  always #5 clk = ~clk;

  aes_enc_feeder #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .iv(iv), .iv_load(iv_load), .ready_key(ready_key),
    .iready_enc(iready_enc), .oready_enc(oready_enc), .result_enc(result_enc),
    .block_enc(block_enc), .reset_enc(reset_enc), .busy(busy),
    .blk_count(blk_count)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus-side state (initial block only)
  logic [31:0]  wq[$];
  logic [127:0] sb[$];
  logic [95:0]  tb_stage = '0;
  int           tb_wc = 0;
  int           exp_cnt = 0;
  int           obs_rd = 0;
  logic [127:0] chain_m = '0;
  bit           stale_mode = 1'b0;
  int           lat_cfg = 3;

  // Core-model / monitor state (negedge process only)
  logic [127:0] obs_arr [64];
  int           obs_wr = 0;
  int           dbl = 0;
  int           cd = -1;
  bit           sg = 1'b0;
  logic         prev_re = 1'b0;
  logic [127:0] res_next = '0;

  function automatic logic [127:0] core_fn(input logic [127:0] b);
    if (b == FIPS_PT) return FIPS_CT;
    if (b == CBC_B1)  return CBC_C1;
    return {b[63:0] ^ 64'h0f1e2d3c_4b5a6978, ~b[127:64]};
  endfunction

  // aes_core model and issue monitor: records each started block, raises
  // oready_enc after a latency and holds it until the next start.
  always @(negedge clk) begin
    if (reset) begin
      oready_enc = 1'b0;
      result_enc = '0;
      cd         = -1;
      sg         = 1'b0;
      prev_re    = 1'b0;
      obs_wr     = 0;
    end else begin
      if (reset_enc) begin
        obs_arr[obs_wr % 64] = block_enc;
        obs_wr++;
        if (prev_re) dbl++;
        res_next = core_fn(block_enc);
        if (stale_mode && oready_enc) begin
          sg = 1'b1;
          cd = -1;
        end else begin
          oready_enc = 1'b0;
          cd = lat_cfg;
        end
      end else if (sg) begin
        oready_enc = 1'b0;
        sg = 1'b0;
        cd = 10;
      end else if (cd > 0) begin
        cd--;
      end else if (cd == 0) begin
        oready_enc = 1'b1;
        result_enc = res_next;
        cd = -1;
      end
      prev_re = reset_enc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic queue_block(input logic [127:0] b);
    wq.push_back(b[127:96]);
    wq.push_back(b[95:64]);
    wq.push_back(b[63:32]);
    wq.push_back(b[31:0]);
  endtask

  // Offer queued words until all are taken or the budget runs out.
  task automatic pump(input int budget, output int remaining);
    int c = 0;
    while (wq.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
      in_valid = 1'b1;
      in_data  = wq[0];
      if (in_ready) begin
        wq.delete(0);
        if (tb_wc == 3) sb.push_back({tb_stage, in_data});
        else            tb_stage = {tb_stage[63:0], in_data};
        tb_wc = (tb_wc + 1) % 4;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    remaining = wq.size();
  endtask

  task automatic pump_all(input string tag);
    int rem;
    pump(40, rem);
    chk(tag, rem, 0);
  endtask

  task automatic wait_issue(input string tag);
    int c = 0;
    while (obs_wr == obs_rd && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk(tag, (obs_wr != obs_rd), 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    @(negedge clk);
    while (busy && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("idle_timeout", busy, 1'b0);
  endtask

  // Pop the scoreboard for every observed issue and compare.
  task automatic drain(input string tag);
    logic [127:0] o, pt, ex;
    while (obs_rd != obs_wr) begin
      o = obs_arr[obs_rd % 64];
      obs_rd++;
      if (sb.size() != 0) pt = sb.pop_front();
      else                pt = ~o;
      ex = CBC ? (pt ^ chain_m) : pt;
      chk(tag, o, ex);
      exp_cnt++;
      if (CBC) chain_m = core_fn(ex);
    end
    chk({tag, "_sb_left"}, sb.size(), 0);
    chk({tag, "_count"}, blk_count, exp_cnt[15:0]);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},  in_ready,  1'b1);
    chk({tag, "_block_enc"}, block_enc, '0);
    chk({tag, "_reset_enc"}, reset_enc, 1'b0);
    chk({tag, "_busy"},      busy,      1'b0);
    chk({tag, "_blk_count"}, blk_count, '0);
  endtask

  initial begin
    int rem;

    // Reset values
    #1 reset = 1'b1;
    #1 check_reset_vals("rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // FIPS-197 ECB vector with issue latency and single-cycle start pulse
    queue_block(FIPS_PT);
    pump_all("fips_pump");
    chk("fips_early_start", reset_enc, 1'b0);
    chk("fips_early_block", block_enc, '0);
    @(negedge clk);
    chk("fips_start", reset_enc, 1'b1);
    chk("fips_block", block_enc, FIPS_PT);
    @(negedge clk);
    chk("fips_pulse_len", reset_enc, 1'b0);
    wait_idle(50);
    drain("fips");

    // Stale oready_enc held through START and GUARD
    stale_mode = 1'b1;
    queue_block(128'h00112233_44556677_8899aabb_ccddeeff);
    pump_all("stale_pump");
    wait_issue("stale_issue");
    repeat (6) @(negedge clk);
    chk("stale_no_count", blk_count, exp_cnt[15:0]);
    wait_idle(60);
    drain("stale");
    stale_mode = 1'b0;

    // Key not ready: FIFO fills, staging fills, no issue
    ready_key = 1'b0;
    queue_block(128'h11111111_22222222_33333333_44444444);
    queue_block(128'h55555555_66666666_77777777_88888888);
    queue_block(128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc);
    pump(30, rem);
    chk("nokey_remaining", rem, 1);
    chk("nokey_in_ready", in_ready, 1'b0);
    chk("nokey_word_cnt", dut.word_cnt, 2'd3);
    chk("nokey_no_issue", obs_wr - obs_rd, 0);
    ready_key = 1'b1;
    pump_all("nokey_pump");
    wait_idle(120);
    drain("nokey");

    // IV load then two chained blocks (ECB build: IV ignored)
    @(negedge clk);
    iv = CBC_IV;
    iv_load = 1'b1;
    @(negedge clk);
    iv_load = 1'b0;
    if (CBC) chain_m = CBC_IV;
    queue_block(CBC_PT1);
    queue_block(CBC_PT2);
    pump_all("cbc_pump");
    wait_issue("cbc_issue");
    chk("cbc_first", obs_arr[obs_rd % 64], CBC ? CBC_B1 : CBC_PT1);
    wait_idle(80);
    drain("cbc");

    // Reset in WAIT with one FIFO entry and two staged words
    lat_cfg = 40;
    queue_block(128'hdeadbeef_01234567_89abcdef_fedcba98);
    pump_all("rmid_pump_a");
    wait_issue("rmid_issue");
    queue_block(128'hcafef00d_cafef00d_cafef00d_cafef00d);
    wq.push_back(32'ha5a5a5a5);
    wq.push_back(32'h5a5a5a5a);
    pump_all("rmid_pump_b");
    chk("rmid_busy", busy, 1'b1);
    chk("rmid_staged", dut.word_cnt, 2'd2);
    #2 reset = 1'b1;
    #1 check_reset_vals("rmid");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
    tb_wc = 0;
    tb_stage = '0;
    obs_rd = 0;
    exp_cnt = 0;
    chain_m = '0;
    lat_cfg = 3;
    queue_block(128'h0badf00d_13579bdf_2468ace0_facefeed);
    pump_all("fresh_pump");
    wait_idle(50);
    drain("fresh");

    // Counter wrap
    @(negedge clk);
    force dut.done_cnt = 16'hffff;
    @(negedge clk);
    release dut.done_cnt;
    exp_cnt = 16'hffff;
    chk("wrap_preload", blk_count, 16'hffff);
    queue_block(128'h0f0f0f0f_f0f0f0f0_3c3c3c3c_c3c3c3c3);
    pump_all("wrap_pump");
    wait_idle(50);
    drain("wrap");
    chk("wrap_zero", blk_count, 16'h0000);

    chk("double_pulse", dbl, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
